// File: rtl/spi_slave_if.sv
// User-side handshake bundle of the SPI mode-0 responder: response byte in,
// received byte and status out.
interface spi_slave_if;
   logic [7:0] tx_byte;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       tx_underrun;
   logic       busy;

   modport slave (
      input  tx_byte, tx_valid,
      output tx_ready, rx_byte, rx_valid, tx_underrun, busy
   );

   modport master (
      output tx_byte, tx_valid,
      input  tx_ready, rx_byte, rx_valid, tx_underrun, busy
   );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples the SPI pins in the clk domain and
// shifts bytes MSB-first both ways, with a single-entry response holding register.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | synced CS inactive; MISO released, edge events ignored
// ST_ACTIVE | synced CS active; shifting on synced spi_clk rise/fall
module spi_slave #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   spi_slave_if.slave bus,
   input  logic       spi_clk,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_prev;
   logic                   sclk_cur;
   logic                   cs_cur;
   logic                   mosi_cur;
   logic                   rise;
   logic                   fall;

   logic [0:0] state;
   logic [2:0] bit_cnt;
   logic       reload_pend;
   logic [7:0] rx_shift;
   logic [7:0] tx_shift;
   logic [7:0] rx_byte_q;
   logic       rx_valid_q;
   logic       underrun_q;
   logic [7:0] hold_data;
   logic       hold_full;
   logic       hold_wr;
   logic       load;

   // Identical chains on all three pins keep MOSI aligned with the clock edges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sclk_prev <= sclk_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_cur = sclk_sync[SYNC_STAGES-1];
   assign cs_cur   = cs_sync[SYNC_STAGES-1];
   assign mosi_cur = mosi_sync[SYNC_STAGES-1];
   assign rise     = sclk_cur & ~sclk_prev;
   assign fall     = ~sclk_cur & sclk_prev;

   assign load = ((state == ST_IDLE) & ~cs_cur) |
                 ((state == ST_ACTIVE) & ~cs_cur & fall & reload_pend);
   assign hold_wr = bus.tx_valid & ~hold_full;

   // A write landing in the same cycle as a load is captured for the next byte;
   // the load itself already saw the register empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_data <= '0;
         hold_full <= 1'b0;
      end else if (hold_wr) begin
         hold_data <= bus.tx_byte;
         hold_full <= 1'b1;
      end else if (load) begin
         hold_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         reload_pend <= 1'b0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         rx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         underrun_q <= load & ~hold_full;
         if (load) begin
            tx_shift <= hold_full ? hold_data : DEFAULT_TX;
         end
         if (state == ST_IDLE) begin
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            if (!cs_cur) begin
               state <= ST_ACTIVE;
            end
         end else begin
            if (cs_cur) begin
               state       <= ST_IDLE;
               bit_cnt     <= '0;
               reload_pend <= 1'b0;
            end else if (rise) begin
               rx_shift <= {rx_shift[6:0], mosi_cur};
               bit_cnt  <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  rx_byte_q   <= {rx_shift[6:0], mosi_cur};
                  rx_valid_q  <= 1'b1;
                  reload_pend <= 1'b1;
               end
            end else if (fall) begin
               if (reload_pend) begin
                  reload_pend <= 1'b0;
               end else begin
                  tx_shift <= {tx_shift[6:0], 1'b0};
               end
            end
         end
      end
   end

   assign bus.tx_ready    = ~hold_full;
   assign bus.rx_byte     = rx_byte_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.tx_underrun = underrun_q;
   assign bus.busy        = (state == ST_ACTIVE);
   assign spi_miso        = (state == ST_ACTIVE) ? tx_shift[7] : 1'bz;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 master model drives the pins, expected bytes are
// queued when stimulus is issued and compared as the responder produces them.
module tb_spi_slave;
   localparam int HP      = 5;
   localparam int CS_LEAD = 6;

   logic clk      = 1'b0;
   logic reset    = 1'b1;
   logic spi_clk  = 1'b0;
   logic spi_cs_n = 1'b1;
   logic spi_mosi = 1'b0;
   wire  spi_miso;

   spi_slave_if bus ();

   spi_slave #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .spi_clk  (spi_clk),
      .spi_cs_n (spi_cs_n),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso)
   );

   // A released MISO reads as 1; the responder drives 0 from a freshly reset shifter.
   pullup (spi_miso);

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int rx_cnt = 0;
   int ur_cnt = 0;
   logic [7:0] rx_log[$];
   logic [7:0] exp_rx[$];
   logic [7:0] exp_tx[$];

   always @(negedge clk) begin
      if (bus.rx_valid === 1'b1) begin
         rx_log.push_back(bus.rx_byte);
         rx_cnt++;
      end
      if (bus.tx_underrun === 1'b1) ur_cnt++;
   end

   task automatic do_reset();
      reset = 1'b1;
      spi_clk = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      bus.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic write_hold(input logic [7:0] b);
      bus.tx_byte = b;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      repeat (CS_LEAD) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (3) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = '0;
      for (int k = 0; k < nbits; k++) begin
         spi_mosi = mo[7-k];
         repeat (HP) @(negedge clk);
         mi[7-k] = spi_miso;
         spi_clk = 1'b1;
         repeat (HP) @(negedge clk);
         spi_clk = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte: got %h expected 00", bus.rx_byte); end
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
      checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", bus.tx_underrun); end
      checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", bus.tx_ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (spi_miso !== 1'b1) begin errors++; $display("FAIL reset_miso_released: got %b expected released (1)", spi_miso); end
   endtask

   task automatic test_single_byte();
      logic [7:0] mi, got, exp;
      int rx0, ur0, rd;
      do_reset();
      exp_tx.push_back(8'hA5);
      exp_rx.push_back(8'h3C);
      write_hold(8'hA5);
      rx0 = rx_cnt; ur0 = ur_cnt; rd = rx_log.size();
      spi_cs_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL single_ready_before_load: got %b expected 0", bus.tx_ready); end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
      checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL single_ready_after_load: got %b expected 1", bus.tx_ready); end
      repeat (CS_LEAD - 3) @(negedge clk);
      xfer(8'h3C, 8, mi);
      exp = exp_tx.pop_front();
      checks++; if (mi !== exp) begin errors++; $display("FAIL single_miso: got %h expected %h", mi, exp); end
      checks++; if (ur_cnt - ur0 != 0) begin errors++; $display("FAIL single_underrun: got %0d pulses expected 0", ur_cnt - ur0); end
      checks++; if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL single_rx_count: got %0d expected 1", rx_cnt - rx0); end
      got = (rx_log.size() > rd) ? rx_log[rd] : 8'h00;
      exp = exp_rx.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL single_rx_byte: got %h expected %h", got, exp); end
      cs_high();
   endtask

   task automatic test_back_to_back();
      logic [7:0] mi[3];
      logic [7:0] got, exp;
      logic [7:0] tx_seq[3];
      int rx0, rd;
      bit done;
      do_reset();
      tx_seq[0] = 8'h01; tx_seq[1] = 8'h02; tx_seq[2] = 8'h03;
      for (int i = 0; i < 3; i++) begin
         exp_rx.push_back(tx_seq[i]);
         exp_tx.push_back(8'h10);
      end
      write_hold(8'h10);
      rx0 = rx_cnt; rd = rx_log.size();
      done = 1'b0;
      fork
         begin
            cs_low();
            for (int i = 0; i < 3; i++) xfer(tx_seq[i], 8, mi[i]);
            cs_high();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               bus.tx_valid = 1'b0;
               if (!done && bus.tx_ready === 1'b1) begin
                  bus.tx_byte = 8'h10;
                  bus.tx_valid = 1'b1;
               end
            end
            bus.tx_valid = 1'b0;
         end
      join
      for (int i = 0; i < 3; i++) begin
         exp = exp_tx.pop_front();
         checks++; if (mi[i] !== exp) begin errors++; $display("FAIL b2b_miso[%0d]: got %h expected %h", i, mi[i], exp); end
      end
      checks++; if (rx_cnt - rx0 != 3) begin errors++; $display("FAIL b2b_rx_count: got %0d expected 3", rx_cnt - rx0); end
      for (int i = 0; i < 3; i++) begin
         got = (rx_log.size() > rd + i) ? rx_log[rd+i] : 8'h00;
         exp = exp_rx.pop_front();
         checks++; if (got !== exp) begin errors++; $display("FAIL b2b_rx_byte[%0d]: got %h expected %h", i, got, exp); end
      end
   endtask

   task automatic test_underrun();
      logic [7:0] mi, got, exp;
      int rx0, ur0, rd;
      do_reset();
      exp_tx.push_back(8'hFF);
      exp_rx.push_back(8'h55);
      rx0 = rx_cnt; ur0 = ur_cnt; rd = rx_log.size();
      spi_cs_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.tx_underrun !== 1'b1) begin errors++; $display("FAIL underrun_at_cs_fall: got %b expected 1", bus.tx_underrun); end
      repeat (CS_LEAD - 3) @(negedge clk);
      xfer(8'h55, 8, mi);
      exp = exp_tx.pop_front();
      checks++; if (mi !== exp) begin errors++; $display("FAIL underrun_miso: got %h expected %h", mi, exp); end
      checks++; if (ur_cnt - ur0 != 1) begin errors++; $display("FAIL underrun_count: got %0d expected 1", ur_cnt - ur0); end
      checks++; if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL underrun_rx_count: got %0d expected 1", rx_cnt - rx0); end
      got = (rx_log.size() > rd) ? rx_log[rd] : 8'h00;
      exp = exp_rx.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL underrun_rx_byte: got %h expected %h", got, exp); end
      cs_high();
   endtask

   task automatic test_abort();
      logic [7:0] mi, got, exp;
      int rx0, rd;
      do_reset();
      rx0 = rx_cnt;
      cs_low();
      xfer(8'hF0, 4, mi);
      cs_high();
      checks++; if (rx_cnt - rx0 != 0) begin errors++; $display("FAIL abort_no_rx: got %0d pulses expected 0", rx_cnt - rx0); end
      exp_rx.push_back(8'hC3);
      rx0 = rx_cnt; rd = rx_log.size();
      cs_low();
      xfer(8'hC3, 8, mi);
      cs_high();
      checks++; if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL abort_next_count: got %0d expected 1", rx_cnt - rx0); end
      got = (rx_log.size() > rd) ? rx_log[rd] : 8'h00;
      exp = exp_rx.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL abort_next_byte: got %h expected %h", got, exp); end
   endtask

   task automatic test_collision();
      logic [7:0] mi0, mi1, got, exp;
      int rd;
      do_reset();
      exp_tx.push_back(8'hFF);
      exp_tx.push_back(8'h77);
      exp_rx.push_back(8'h11);
      exp_rx.push_back(8'h22);
      rd = rx_log.size();
      spi_cs_n = 1'b0;
      repeat (2) @(negedge clk);
      bus.tx_byte = 8'h77;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL coll_busy: got %b expected 1", bus.busy); end
      checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL coll_tx_ready: got %b expected 0", bus.tx_ready); end
      checks++; if (bus.tx_underrun !== 1'b1) begin errors++; $display("FAIL coll_underrun: got %b expected 1", bus.tx_underrun); end
      repeat (CS_LEAD - 3) @(negedge clk);
      xfer(8'h11, 8, mi0);
      xfer(8'h22, 8, mi1);
      cs_high();
      exp = exp_tx.pop_front();
      checks++; if (mi0 !== exp) begin errors++; $display("FAIL coll_miso0: got %h expected %h", mi0, exp); end
      exp = exp_tx.pop_front();
      checks++; if (mi1 !== exp) begin errors++; $display("FAIL coll_miso1: got %h expected %h", mi1, exp); end
      for (int i = 0; i < 2; i++) begin
         got = (rx_log.size() > rd + i) ? rx_log[rd+i] : 8'h00;
         exp = exp_rx.pop_front();
         checks++; if (got !== exp) begin errors++; $display("FAIL coll_rx_byte[%0d]: got %h expected %h", i, got, exp); end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] mi, got, exp;
      int rx0, rd;
      do_reset();
      cs_low();
      xfer(8'h5A, 8, mi);
      xfer(8'hE7, 5, mi);
      write_hold(8'h33);
      checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL arst_pre_ready: got %b expected 0", bus.tx_ready); end
      checks++; if (bus.rx_byte !== 8'h5A) begin errors++; $display("FAIL arst_pre_rx_byte: got %h expected 5a", bus.rx_byte); end
      @(negedge clk);
      #2;
      reset = 1'b1;
      spi_cs_n = 1'b1;
      spi_clk = 1'b0;
      #1;
      checks++; if (bus.rx_byte !== 8'h00) begin errors++; $display("FAIL arst_rx_byte: got %h expected 00", bus.rx_byte); end
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL arst_rx_valid: got %b expected 0", bus.rx_valid); end
      checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL arst_underrun: got %b expected 0", bus.tx_underrun); end
      checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL arst_tx_ready: got %b expected 1", bus.tx_ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
      checks++; if (spi_miso !== 1'b1) begin errors++; $display("FAIL arst_miso_released: got %b expected released (1)", spi_miso); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      exp_rx.push_back(8'h96);
      rx0 = rx_cnt; rd = rx_log.size();
      cs_low();
      xfer(8'h96, 8, mi);
      cs_high();
      checks++; if (rx_cnt - rx0 != 1) begin errors++; $display("FAIL arst_after_count: got %0d expected 1", rx_cnt - rx0); end
      got = (rx_log.size() > rd) ? rx_log[rd] : 8'h00;
      exp = exp_rx.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL arst_after_byte: got %h expected %h", got, exp); end
   endtask

   initial begin
      bus.tx_byte = 8'h00;
      bus.tx_valid = 1'b0;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_collision();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
